// File: rtl/mux_scan_capture_if.sv
// Handshake and data bundle between the scan sequencer and its controller/mux.
// The master drives start/cont/abort and y_in; the slave is the sequencer.
interface mux_scan_capture_if #(
    parameter int unsigned SEL_W = 4
);
    localparam int unsigned N = 2 ** SEL_W;

    logic             start;
    logic             cont;
    logic             abort;
    logic             y_in;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     data_out;
    logic             valid;
    logic             busy;

    modport master (
        output start, cont, abort, y_in,
        input  sel, data_out, valid, busy
    );

    modport slave (
        input  start, cont, abort, y_in,
        output sel, data_out, valid, busy
    );
endinterface

// File: rtl/mux_scan_capture.sv
// Scans a 2**SEL_W:1 mux channel by channel, holding each select for SETTLE+1 cycles,
// and publishes the assembled frame with a one-cycle valid pulse.
module mux_scan_capture #(
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned SETTLE = 0
) (
    input logic                clk,
    input logic                rst,
    mux_scan_capture_if.slave  bus
);
    localparam int unsigned N      = 2 ** SEL_W;
    localparam int unsigned HOLD_W = 4;
    localparam logic [SEL_W-1:0]  SelLast    = SEL_W'(N - 1);
    localparam logic [HOLD_W-1:0] HoldReload = HOLD_W'(SETTLE);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e            r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [HOLD_W-1:0] r_hold;
    logic [N-1:0]      r_shadow;
    logic [N-1:0]      r_data;
    logic              r_valid;
    logic              r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_sel    <= '0;
            r_hold   <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        r_state  <= StScan;
                        r_sel    <= '0;
                        r_hold   <= HoldReload;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                StScan: begin
                    if (bus.abort) begin
                        // Partial frame is dropped; data_out keeps the last complete one.
                        r_state  <= StIdle;
                        r_sel    <= '0;
                        r_hold   <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b0;
                    end else if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end else if (r_sel != SelLast) begin
                        r_shadow[r_sel] <= bus.y_in;
                        r_sel           <= r_sel + 1'b1;
                        r_hold          <= HoldReload;
                    end else begin
                        // Last channel bypasses the shadow so the frame lands on this edge.
                        r_data  <= {bus.y_in, r_shadow[N-2:0]};
                        r_valid <= 1'b1;
                        r_sel   <= '0;
                        r_hold  <= HoldReload;
                        r_shadow <= '0;
                        if (!bus.cont) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                            r_hold  <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_sel   <= '0;
                    r_hold  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel      = r_sel;
    assign bus.data_out = r_data;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_mux_scan_capture.sv
// Drives two sequencers (SETTLE=0 and SETTLE=2) from shared stimulus, each feeding a 16:1 mux
// model, and compares every cycle against a frame-timing reference model.
module tb_mux_scan_capture;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned N     = 16;
    localparam int unsigned NDUT  = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cont;
    logic        abort;
    logic [15:0] mux_in;

    logic [NDUT-1:0][3:0]  sel_o;
    logic [NDUT-1:0][15:0] data_o;
    logic [NDUT-1:0]       valid_o;
    logic [NDUT-1:0]       busy_o;

    int n_vec;
    int n_err;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mux_scan_capture_if #(.SEL_W(SEL_W)) bus ();

        assign bus.start = start;
        assign bus.cont  = cont;
        assign bus.abort = abort;
        assign bus.y_in  = mux_in[bus.sel];

        assign sel_o[g]   = bus.sel;
        assign data_o[g]  = bus.data_out;
        assign valid_o[g] = bus.valid;
        assign busy_o[g]  = bus.busy;

        mux_scan_capture #(
            .SEL_W (SEL_W),
            .SETTLE(2 * g)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a frame is a cycle count k since start; channel = k / (SETTLE+1).
    logic        m_busy  [NDUT];
    int          m_k     [NDUT];
    logic [15:0] m_frame [NDUT];
    logic [15:0] m_data  [NDUT];
    logic        m_valid [NDUT];

    function automatic int settle_of(input int d);
        return 2 * d;
    endfunction

    function automatic logic [3:0] m_sel(input int d);
        return m_busy[d] ? 4'(m_k[d] / (settle_of(d) + 1)) : 4'd0;
    endfunction

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            m_busy[d] = 0; m_k[d] = 0; m_frame[d] = 0; m_data[d] = 0; m_valid[d] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int d = 0; d < NDUT; d++) begin
                int per;
                int ch;
                per = settle_of(d) + 1;
                if (rst) begin
                    m_busy[d] = 0; m_k[d] = 0; m_frame[d] = 0; m_data[d] = 0; m_valid[d] = 0;
                end else begin
                    m_valid[d] = 0;
                    if (!m_busy[d]) begin
                        if (start && !abort) begin
                            m_busy[d] = 1; m_k[d] = 0; m_frame[d] = 0;
                        end
                    end else if (abort) begin
                        m_busy[d] = 0; m_k[d] = 0;
                    end else begin
                        ch = m_k[d] / per;
                        if (m_k[d] % per == per - 1) m_frame[d][ch] = mux_in[ch];
                        m_k[d]++;
                        if (m_k[d] == int'(N) * per) begin
                            m_data[d]  = m_frame[d];
                            m_valid[d] = 1;
                            m_k[d]     = 0;
                            m_frame[d] = 0;
                            if (!cont) m_busy[d] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("sel%0d", d),   32'(sel_o[d]),   32'(m_sel(d)));
            check_eq($sformatf("busy%0d", d),  32'(busy_o[d]),  32'(m_busy[d]));
            check_eq($sformatf("valid%0d", d), 32'(valid_o[d]), 32'(m_valid[d]));
            check_eq($sformatf("data%0d", d),  32'(data_o[d]),  32'(m_data[d]));
        end
    end

    logic [15:0] frames[$];
    logic        found;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; mux_in = 16'hec9a;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, both settle values; a start while busy must not disturb the frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = (i == 5);
        end
        start = 1'b0;
        check_eq("t1_valid", 32'(valid_o[0]), 32'd1);
        check_eq("t1_data",  32'(data_o[0]),  32'hec9a);
        check_eq("t1_busy",  32'(busy_o[0]),  32'd0);
        repeat (32) @(negedge clk);
        check_eq("t2_valid", 32'(valid_o[1]), 32'd1);
        check_eq("t2_data",  32'(data_o[1]),  32'hec9a);
        @(negedge clk);

        // Abort at channel 5 keeps the previous frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (sel_o[0] == 4'd5) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("t4_reach_sel5", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t4_busy",  32'(busy_o[0]),  32'd0);
        check_eq("t4_sel",   32'(sel_o[0]),   32'd0);
        check_eq("t4_valid", 32'(valid_o[0]), 32'd0);
        check_eq("t4_data",  32'(data_o[0]),  32'hec9a);
        @(negedge clk);

        // Continuous mode, input changes during frame 2.
        cont = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) mux_in = 16'h5a3c;
            @(negedge clk);
            if (valid_o[0]) frames.push_back(data_o[0]);
        end
        check_eq("t3_nframes", 32'(frames.size()), 32'd3);
        if (frames.size() >= 3) begin
            check_eq("t3_frame1", 32'(frames[0]), 32'hec9a);
            check_eq("t3_frame3", 32'(frames[2]), 32'h5a3c);
        end
        check_eq("t3_busy", 32'(busy_o[0]), 32'd1);
        cont = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 120 && !found; i++) begin
            @(negedge clk);
            if (busy_o == '0) found = 1'b1;
        end
        check_eq("t3_drain", 32'(found), 32'd1);

        // Asynchronous reset mid-frame at channel 9.
        mux_in = 16'hec9a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (sel_o[0] == 4'd9) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("t5_reach_sel9", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_busy",  32'(busy_o[0]),  32'd0);
        check_eq("t5_sel",   32'(sel_o[0]),   32'd0);
        check_eq("t5_data",  32'(data_o[0]), 32'd0);
        check_eq("t5_valid", 32'(valid_o[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            cont  = $urandom_range(0, 1) == 1;
            abort = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) == 0) mux_in = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0; cont = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
